// File: rtl/fp_pkg.sv
// Shared definitions for the sequential FP divide/sqrt unit and its rounding stage.
package fp_pkg;

  // Control FSM of the divide/sqrt engine.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ITER    = 3'd1,
    SPECIAL = 3'd2,
    ROUND   = 3'd3,
    DONE    = 3'd4
  } fsm_state_e;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector.
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  // Operation and rounding-mode encodings.
  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_SQRT = 1'b1;
  localparam logic RM_RNE  = 1'b0;
  localparam logic RM_RTZ  = 1'b1;

  // Constant helpers return a wide vector; callers size-cast to FLEN.
  localparam int MAX_FLEN = 128;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Positive infinity: exponent all ones, mantissa zero.
  function automatic logic [MAX_FLEN-1:0] fp_inf(input int exp_w, input int man_w);
    return ((MAX_FLEN'(1) << exp_w) - MAX_FLEN'(1)) << man_w;
  endfunction

  // Largest finite magnitude sits one ULP below infinity.
  function automatic logic [MAX_FLEN-1:0] fp_max_finite(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) - MAX_FLEN'(1);
  endfunction

  // Canonical quiet NaN: positive, exponent all ones, mantissa MSB set.
  function automatic logic [MAX_FLEN-1:0] fp_qnan(input int exp_w, input int man_w);
    return fp_inf(exp_w, man_w) | (MAX_FLEN'(1) << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational normalise/round/pack stage. Takes a significand whose leading
// one is in one of its two top bits plus a sticky bit, and produces the packed
// result with overflow (saturate per rounding mode) and flush-to-zero handling.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int FLEN  = 1 + EXP_W + MAN_W,
  localparam int SIG_W = MAN_W + 3,
  localparam int EW    = EXP_W + 2
) (
  input  logic                 sign,
  input  logic signed [EW-1:0] exp_in,
  input  logic [SIG_W-1:0]     sig,
  input  logic                 sticky,
  input  logic                 rm,
  output logic [FLEN-1:0]      result,
  output logic [4:0]           flags
);

  localparam logic [FLEN-1:0]      INF_PAT = FLEN'(fp_inf(EXP_W, MAN_W));
  localparam logic [FLEN-1:0]      MAX_PAT = FLEN'(fp_max_finite(EXP_W, MAN_W));
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ONE = EW'(1);

  logic [MAN_W-1:0]     frac_n;
  logic [MAN_W-1:0]     frac_r;
  logic                 frac_carry;
  logic                 rnd_bit;
  logic                 sticky_n;
  logic                 round_up;
  logic                 inexact;
  logic signed [EW-1:0] exp_n;
  logic signed [EW-1:0] exp_r;

  // Normalise by at most one place, round the fraction, then classify the exponent.
  always_comb begin
    result = '0;
    flags  = '0;
    if (sig[SIG_W-1]) begin
      frac_n   = sig[SIG_W-2:2];
      rnd_bit  = sig[1];
      sticky_n = sig[0] | sticky;
      exp_n    = exp_in;
    end else begin
      frac_n   = sig[SIG_W-3:1];
      rnd_bit  = sig[0];
      sticky_n = sticky;
      exp_n    = exp_in - EXP_ONE;
    end
    inexact  = rnd_bit | sticky_n;
    round_up = (rm == RM_RNE) && rnd_bit && (sticky_n || frac_n[0]);
    // A carry out of the fraction turns 1.11..1 into 10.0, i.e. exponent + 1, fraction 0.
    {frac_carry, frac_r} = {1'b0, frac_n} + {{MAN_W{1'b0}}, round_up};
    exp_r = frac_carry ? (exp_n + EXP_ONE) : exp_n;

    if (!exp_r[EW-1] && (exp_r >= EXP_MAX)) begin
      result         = (rm == RM_RNE) ? {sign, INF_PAT[FLEN-2:0]} : {sign, MAX_PAT[FLEN-2:0]};
      flags[FLAG_OF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else if (exp_r[EW-1] || (exp_r == '0)) begin
      result         = {sign, {(FLEN-1){1'b0}}};
      flags[FLAG_UF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else begin
      result         = {sign, exp_r[EXP_W-1:0], frac_r};
      flags[FLAG_NX] = inexact;
    end
  end

endmodule

// File: rtl/fp_div_sqrt_seq.sv
// Multi-cycle radix-2 IEEE-754 divide / square-root unit. One quotient or root
// bit per cycle; special operands resolve in a single cycle. Subnormal inputs
// are treated as zero and subnormal results flush to zero.
module fp_div_sqrt_seq
  import fp_pkg::*;
#(
  parameter  int EXP_W = 8,
  parameter  int MAN_W = 23,
  localparam int FLEN  = 1 + EXP_W + MAN_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op,
  input  logic            rm,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  output logic            stall,
  output logic            done,
  output logic [FLEN-1:0] result,
  output logic [4:0]      flags
);

  localparam int Q     = MAN_W + 3;   // result bits: normalisation, MAN_W+1 mantissa, round
  localparam int EW    = EXP_W + 2;   // signed exponent intermediate
  localparam int RW    = Q + 4;       // partial remainder, wide enough for the sqrt recurrence
  localparam int RAD_W = 2 * Q;       // radicand consumed two bits per cycle
  localparam int CNT_W = $clog2(Q);
  localparam logic signed [EW-1:0] BIAS_S  = EW'(fp_bias(EXP_W));
  localparam logic [FLEN-1:0]      QNAN    = FLEN'(fp_qnan(EXP_W, MAN_W));
  localparam logic [FLEN-1:0]      INF_PAT = FLEN'(fp_inf(EXP_W, MAN_W));

  // ---------------- operand unpack / classify ----------------
  logic             sa, sb, sq;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, a_inf, a_nan, a_snan;
  logic             b_zero, b_inf, b_nan, b_snan;

  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;
  assign sq     = sa ^ sb;
  assign a_zero = (ea == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign a_snan = a_nan && !fa[MAN_W-1];
  assign b_zero = (eb == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign b_nan  = (eb == '1) && (fb != '0);
  assign b_snan = b_nan && !fb[MAN_W-1];

  logic signed [EW-1:0] ea_s, eb_s, ue, div_exp, sqrt_exp;
  logic [MAN_W:0]       ma, mb;
  logic [MAN_W+1:0]     rad_m;

  assign ma       = {1'b1, fa};
  assign mb       = {1'b1, fb};
  assign ea_s     = EW'(ea);
  assign eb_s     = EW'(eb);
  assign div_exp  = ea_s - eb_s + BIAS_S;
  assign ue       = ea_s - BIAS_S;
  assign sqrt_exp = (ue >>> 1) + BIAS_S;
  // An odd unbiased exponent moves one factor of two into the radicand.
  assign rad_m    = ue[0] ? {ma, 1'b0} : {1'b0, ma};

  logic            spec_hit;
  logic [FLEN-1:0] spec_res;
  logic [4:0]      spec_flags;

  // Special-operand resolution in priority order; spec_hit=0 means normal path.
  always_comb begin
    spec_hit   = 1'b1;
    spec_res   = '0;
    spec_flags = '0;
    if (op == OP_DIV) begin
      if (a_nan || b_nan) begin
        spec_res            = QNAN;
        spec_flags[FLAG_NV] = a_snan | b_snan;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
        spec_res            = QNAN;
        spec_flags[FLAG_NV] = 1'b1;
      end else if (b_zero && !a_inf) begin
        spec_res            = {sq, INF_PAT[FLEN-2:0]};
        spec_flags[FLAG_DZ] = 1'b1;
      end else if (b_inf) begin
        spec_res = {sq, {(FLEN-1){1'b0}}};
      end else if (a_inf) begin
        spec_res = {sq, INF_PAT[FLEN-2:0]};
      end else if (a_zero) begin
        spec_res = {sq, {(FLEN-1){1'b0}}};
      end else begin
        spec_hit = 1'b0;
      end
    end else begin
      if (a_nan) begin
        spec_res            = QNAN;
        spec_flags[FLAG_NV] = a_snan;
      end else if (sa && !a_zero) begin
        spec_res            = QNAN;
        spec_flags[FLAG_NV] = 1'b1;
      end else if (a_zero) begin
        spec_res = {sa, {(FLEN-1){1'b0}}};
      end else if (a_inf) begin
        spec_res = INF_PAT;
      end else begin
        spec_hit = 1'b0;
      end
    end
  end

  // ---------------- state and datapath registers ----------------
  fsm_state_e           state_reg, state_next;
  logic                 op_reg, rm_reg, sign_reg;
  logic signed [EW-1:0] exp_reg;
  logic signed [RW-1:0] rem_reg, rem_step;
  logic [Q-1:0]         quo_reg, quo_step;
  logic [RAD_W-1:0]     rad_reg;
  logic [MAN_W:0]       div_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [FLEN-1:0]      result_reg;
  logic [4:0]           flags_reg;

  logic signed [RW-1:0] div_diff, rem_sh, sqrt_trial;

  // One recurrence step: restoring divide or non-restoring square root.
  always_comb begin
    rem_step   = rem_reg;
    quo_step   = quo_reg;
    div_diff   = rem_reg - RW'(div_reg);
    rem_sh     = {rem_reg[RW-3:0], rad_reg[RAD_W-1 -: 2]};
    sqrt_trial = rem_reg[RW-1] ? (rem_sh + RW'({quo_reg, 2'b11}))
                               : (rem_sh - RW'({quo_reg, 2'b01}));
    if (op_reg == OP_DIV) begin
      if (!div_diff[RW-1]) begin
        rem_step = {div_diff[RW-2:0], 1'b0};
        quo_step = {quo_reg[Q-2:0], 1'b1};
      end else begin
        rem_step = {rem_reg[RW-2:0], 1'b0};
        quo_step = {quo_reg[Q-2:0], 1'b0};
      end
    end else begin
      rem_step = sqrt_trial;
      quo_step = {quo_reg[Q-2:0], ~sqrt_trial[RW-1]};
    end
  end

  // A negative non-restoring remainder is corrected before testing for exactness.
  logic signed [RW-1:0] rem_fix;
  logic                 sticky_fin;
  logic [FLEN-1:0]      rp_result;
  logic [4:0]           rp_flags;

  assign rem_fix    = rem_reg[RW-1] ? (rem_reg + RW'({quo_reg, 1'b1})) : rem_reg;
  assign sticky_fin = (rem_fix != '0);

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .sign   (sign_reg),
    .exp_in (exp_reg),
    .sig    (quo_reg),
    .sticky (sticky_fin),
    .rm     (rm_reg),
    .result (rp_result),
    .flags  (rp_flags)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state decode plus stall/done outputs.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE:    if (start) state_next = spec_hit ? SPECIAL : ITER;
      ITER: begin
        stall = 1'b1;
        if (cnt_reg == '0) state_next = ROUND;
      end
      ROUND: begin
        stall      = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        stall      = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      SPECIAL: begin
        stall      = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on accept, recurrence in ITER, result capture in ROUND.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg     <= 1'b0;
      rm_reg     <= 1'b0;
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      rad_reg    <= '0;
      div_reg    <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg  <= op;
            rm_reg  <= rm;
            quo_reg <= '0;
            cnt_reg <= CNT_W'(Q - 1);
            if (op == OP_DIV) begin
              sign_reg <= sq;
              exp_reg  <= div_exp;
              rem_reg  <= RW'(ma);
              div_reg  <= mb;
              rad_reg  <= '0;
            end else begin
              sign_reg <= 1'b0;
              exp_reg  <= sqrt_exp;
              rem_reg  <= '0;
              div_reg  <= '0;
              rad_reg  <= {rad_m, {(MAN_W+4){1'b0}}};
            end
            if (spec_hit) begin
              result_reg <= spec_res;
              flags_reg  <= spec_flags;
            end
          end
        end
        ITER: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          rad_reg <= rad_reg << 2;
          cnt_reg <= cnt_reg - 1'b1;
        end
        ROUND: begin
          result_reg <= rp_result;
          flags_reg  <= rp_flags;
        end
        default: ;
      endcase
    end
  end

  assign result = result_reg;
  assign flags  = flags_reg;

endmodule
